// File: rtl/phv_action_issue_sched_pkg.sv
// Shared constants, state encoding and helpers for the PHV/action issue scheduler.
package phv_action_issue_sched_pkg;

    // PHV width: 8x48b + 8x32b + 8x16b containers, 5x20b fields, 256b metadata.
    localparam int PHV_LEN_DEF    = 1124;
    localparam int ACT_LEN_DEF    = 25;
    localparam int ACT_NUM_DEF    = 25;
    localparam int FIFO_DEPTH_DEF = 4;

    // Sub-action slot layout inside one action word, shared with the crossbar/ALU blocks.
    localparam int SLOTS_PER_TYPE = 8;
    localparam int SLOT_6B_BASE   = 0;
    localparam int SLOT_4B_BASE   = 8;
    localparam int SLOT_2B_BASE   = 16;
    localparam int SLOT_MD        = 24;

    // Sequencer state: RUN accepts and issues, FLUSH discards everything buffered.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } schedState_e;

    // Occupancy count width for a FIFO of the given depth (must hold 0..depth).
    function automatic int cntWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/phv_action_issue_sched_if.sv
// Handshake/data bundle between the scheduler and its upstream/engine neighbours.
interface phv_action_issue_sched_if #(
    parameter int PHV_LEN = phv_action_issue_sched_pkg::PHV_LEN_DEF,
    parameter int ACT_LEN = phv_action_issue_sched_pkg::ACT_LEN_DEF,
    parameter int ACT_NUM = phv_action_issue_sched_pkg::ACT_NUM_DEF,
    parameter int CNT_W   = phv_action_issue_sched_pkg::cntWidth(phv_action_issue_sched_pkg::FIFO_DEPTH_DEF)
);
    logic [PHV_LEN-1:0]         phv_in;
    logic                       phv_valid_in;
    logic                       phv_ready_out;
    logic [ACT_LEN*ACT_NUM-1:0] action_in;
    logic                       action_valid_in;
    logic                       action_ready_out;
    logic [PHV_LEN-1:0]         phv_out;
    logic                       phv_valid_out;
    logic [ACT_LEN*ACT_NUM-1:0] action_out;
    logic                       action_valid_out;
    logic                       engine_ready_in;
    logic                       flush_in;
    logic [CNT_W-1:0]           phv_cnt;
    logic [CNT_W-1:0]           act_cnt;
    logic [1:0]                 ovf_err;
    logic                       err_clr;
    logic [31:0]                issue_cnt;

    // Environment side: parser, lookup engine, action engine and control.
    modport master (
        output phv_in, phv_valid_in, action_in, action_valid_in,
        output engine_ready_in, flush_in, err_clr,
        input  phv_ready_out, action_ready_out, phv_out, phv_valid_out,
        input  action_out, action_valid_out, phv_cnt, act_cnt, ovf_err, issue_cnt
    );

    // Scheduler side.
    modport slave (
        input  phv_in, phv_valid_in, action_in, action_valid_in,
        input  engine_ready_in, flush_in, err_clr,
        output phv_ready_out, action_ready_out, phv_out, phv_valid_out,
        output action_out, action_valid_out, phv_cnt, act_cnt, ovf_err, issue_cnt
    );
endinterface

// File: rtl/phv_action_issue_sched_fifo.sv
// Synchronous FIFO with pointer+count bookkeeping; DEPTH must be a power of 2, >= 2.
module sched_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally at DEPTH; reset and clear both empty the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rdPtr_q];
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/phv_action_issue_sched.sv
// Per-stage sequencer pairing PHVs with action words and issuing them to the action engine.
module phv_action_issue_sched
    import phv_action_issue_sched_pkg::*;
#(
    parameter int PHV_LEN    = PHV_LEN_DEF,
    parameter int ACT_LEN    = ACT_LEN_DEF,
    parameter int ACT_NUM    = ACT_NUM_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    phv_action_issue_sched_if.slave   bus
);
    localparam int ACT_W = ACT_LEN * ACT_NUM;

    schedState_e       state_q;
    logic              outValid_q;
    logic [PHV_LEN-1:0] phvOut_q;
    logic [ACT_W-1:0]  actOut_q;
    logic [31:0]       issueCnt_q;
    logic [31:0]       issueCnt_d;
    logic [1:0]        ovf_q;
    logic [1:0]        ovf_d;

    logic              phvFull;
    logic              phvEmpty;
    logic              actFull;
    logic              actEmpty;
    logic [CNT_W-1:0]  phvCount;
    logic [CNT_W-1:0]  actCount;
    logic [PHV_LEN-1:0] phvHead;
    logic [ACT_W-1:0]  actHead;

    logic              inRun;
    logic              runNoFlush;
    logic              issue;
    logic              phvPush;
    logic              actPush;
    logic              phvDrop;
    logic              actDrop;
    logic              fifoClr;

    // Push/pop/drop decisions; a flush request blocks both pushes and issue that cycle.
    always_comb begin
        inRun      = (state_q == ST_RUN);
        runNoFlush = inRun && !bus.flush_in;
        issue      = runNoFlush && !phvEmpty && !actEmpty && bus.engine_ready_in;
        phvPush    = runNoFlush && bus.phv_valid_in && !phvFull;
        actPush    = runNoFlush && bus.action_valid_in && !actFull;
        phvDrop    = inRun && bus.phv_valid_in && phvFull;
        actDrop    = inRun && bus.action_valid_in && actFull;
        fifoClr    = (state_q == ST_FLUSH);
    end

    // Counter and sticky error next values; a new drop wins over a same-cycle clear.
    always_comb begin
        issueCnt_d = issueCnt_q + 32'(issue);
        ovf_d      = bus.err_clr ? 2'b00 : ovf_q;
        ovf_d      = ovf_d | {phvDrop, actDrop};
    end

    sched_sync_fifo #(
        .WIDTH (PHV_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_phvFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (fifoClr),
        .push_i  (phvPush),
        .pop_i   (issue),
        .data_i  (bus.phv_in),
        .data_o  (phvHead),
        .full_o  (phvFull),
        .empty_o (phvEmpty),
        .count_o (phvCount)
    );

    sched_sync_fifo #(
        .WIDTH (ACT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_actFifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (fifoClr),
        .push_i  (actPush),
        .pop_i   (issue),
        .data_i  (bus.action_in),
        .data_o  (actHead),
        .full_o  (actFull),
        .empty_o (actEmpty),
        .count_o (actCount)
    );

    // RUN/FLUSH controller with registered issue pulse, issue data and counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            outValid_q <= 1'b0;
            phvOut_q   <= '0;
            actOut_q   <= '0;
            issueCnt_q <= '0;
            ovf_q      <= '0;
        end else begin
            issueCnt_q <= issueCnt_d;
            ovf_q      <= ovf_d;
            case (state_q)
                ST_RUN: begin
                    if (bus.flush_in) begin
                        state_q    <= ST_FLUSH;
                        outValid_q <= 1'b0;
                    end else begin
                        outValid_q <= issue;
                        if (issue) begin
                            phvOut_q <= phvHead;
                            actOut_q <= actHead;
                        end
                    end
                end
                ST_FLUSH: begin
                    outValid_q <= 1'b0;
                    state_q    <= bus.flush_in ? ST_FLUSH : ST_RUN;
                end
                default: begin
                    outValid_q <= 1'b0;
                    state_q    <= ST_RUN;
                end
            endcase
        end
    end

    // Readies depend only on occupancy and state, never on a same-cycle pop.
    assign bus.phv_ready_out    = rst_n && inRun && !phvFull;
    assign bus.action_ready_out = rst_n && inRun && !actFull;
    assign bus.phv_out          = phvOut_q;
    assign bus.action_out       = actOut_q;
    assign bus.phv_valid_out    = outValid_q;
    assign bus.action_valid_out = outValid_q;
    assign bus.phv_cnt          = phvCount;
    assign bus.act_cnt          = actCount;
    assign bus.ovf_err          = ovf_q;
    assign bus.issue_cnt        = issueCnt_q;

endmodule

// File: tb/tb_phv_action_issue_sched.sv
// Self-checking bench: queue-based reference model compared every cycle plus directed literal checks.
module tb_phv_action_issue_sched;
    localparam int PHV_LEN = 1124;
    localparam int ACT_LEN = 25;
    localparam int ACT_NUM = 25;
    localparam int ACT_W   = ACT_LEN * ACT_NUM;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = 3;
    localparam int W       = PHV_LEN;

    logic clk;
    logic rst_n;

    phv_action_issue_sched_if #(
        .PHV_LEN (PHV_LEN), .ACT_LEN (ACT_LEN), .ACT_NUM (ACT_NUM), .CNT_W (CNT_W)
    ) bus ();

    phv_action_issue_sched #(
        .PHV_LEN (PHV_LEN), .ACT_LEN (ACT_LEN), .ACT_NUM (ACT_NUM),
        .FIFO_DEPTH (DEPTH), .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vecCount  = 0;
    int missCount = 0;
    int pulseCount = 0;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: arrival-ordered queues and expected registered outputs.
    logic [PHV_LEN-1:0] mPhvQ [$];
    logic [ACT_W-1:0]   mActQ [$];
    bit                 modelLive = 0;
    bit                 mFlush    = 0;
    logic               expValid  = 1'b0;
    logic [PHV_LEN-1:0] expPhv    = '0;
    logic [ACT_W-1:0]   expAct    = '0;
    logic [31:0]        expIssue  = '0;
    logic [1:0]         expOvf    = '0;

    function automatic logic [PHV_LEN-1:0] a5Pattern();
        logic [1127:0] t;
        t = {141{8'hA5}};
        return t[PHV_LEN-1:0];
    endfunction

    function automatic logic [PHV_LEN-1:0] mkPhv(input int k);
        return a5Pattern() ^ PHV_LEN'(k) ^ (PHV_LEN'(k) << 1000);
    endfunction

    function automatic logic [ACT_W-1:0] mkAct(input int k);
        return ACT_W'(k) | (ACT_W'(k) << 600);
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h required 0x%0h (low 64 bits)",
                     name, $time, actual[63:0], expected[63:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit pv, input logic [PHV_LEN-1:0] pd,
                                 input bit av, input logic [ACT_W-1:0] ad,
                                 input bit er, input bit fl = 1'b0, input bit ec = 1'b0);
        bus.phv_valid_in    = pv;
        bus.phv_in          = pd;
        bus.action_valid_in = av;
        bus.action_in       = ad;
        bus.engine_ready_in = er;
        bus.flush_in        = fl;
        bus.err_clr         = ec;
        tick();
    endtask

    task automatic idle(input bit er);
        applyStimulus(1'b0, '0, 1'b0, '0, er);
    endtask

    // Model update from the rules: pairing in arrival order, one pop per FIFO per issue.
    always @(posedge clk) begin
        bit phvFullNow;
        bit actFullNow;
        bit doIssue;
        modelLive = 1;
        if (!rst_n) begin
            mPhvQ.delete();
            mActQ.delete();
            mFlush   = 0;
            expValid = 1'b0;
            expPhv   = '0;
            expAct   = '0;
            expIssue = '0;
            expOvf   = '0;
        end else if (mFlush) begin
            mPhvQ.delete();
            mActQ.delete();
            expValid = 1'b0;
            if (bus.err_clr) expOvf = 2'b00;
            mFlush = bus.flush_in;
        end else begin
            phvFullNow = (mPhvQ.size() == DEPTH);
            actFullNow = (mActQ.size() == DEPTH);
            if (bus.err_clr) expOvf = 2'b00;
            if (bus.phv_valid_in && phvFullNow) expOvf[1] = 1'b1;
            if (bus.action_valid_in && actFullNow) expOvf[0] = 1'b1;
            if (bus.flush_in) begin
                mFlush   = 1;
                expValid = 1'b0;
            end else begin
                doIssue = (mPhvQ.size() > 0) && (mActQ.size() > 0) && bus.engine_ready_in;
                if (doIssue) begin
                    expPhv   = mPhvQ.pop_front();
                    expAct   = mActQ.pop_front();
                    expIssue = expIssue + 1;
                end
                expValid = doIssue;
                if (bus.phv_valid_in && !phvFullNow) mPhvQ.push_back(bus.phv_in);
                if (bus.action_valid_in && !actFullNow) mActQ.push_back(bus.action_in);
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("phv_valid_out", W'(bus.phv_valid_out), W'(expValid));
            checkOutput("action_valid_out", W'(bus.action_valid_out), W'(expValid));
            if (expValid) begin
                checkOutput("phv_out", W'(bus.phv_out), W'(expPhv));
                checkOutput("action_out", W'(bus.action_out), W'(expAct));
            end
            checkOutput("phv_cnt", W'(bus.phv_cnt), W'(mPhvQ.size()));
            checkOutput("act_cnt", W'(bus.act_cnt), W'(mActQ.size()));
            checkOutput("phv_ready_out", W'(bus.phv_ready_out),
                        W'(rst_n && !mFlush && (mPhvQ.size() < DEPTH)));
            checkOutput("action_ready_out", W'(bus.action_ready_out),
                        W'(rst_n && !mFlush && (mActQ.size() < DEPTH)));
            checkOutput("ovf_err", W'(bus.ovf_err), W'(expOvf));
            checkOutput("issue_cnt", W'(bus.issue_cnt), W'(expIssue));
            if (bus.phv_valid_out === 1'b1) pulseCount++;
        end
    end

    // Safety net so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios with hand-computed expectations.
    initial begin
        int pulseBase;
        rst_n = 1'b0;
        bus.phv_valid_in = 0; bus.phv_in = '0; bus.action_valid_in = 0; bus.action_in = '0;
        bus.engine_ready_in = 0; bus.flush_in = 0; bus.err_clr = 0;

        // Reset state
        repeat (3) idle(1'b0);
        checkOutput("rst_phv_ready", W'(bus.phv_ready_out), W'(0));
        checkOutput("rst_valid", W'(bus.phv_valid_out), W'(0));
        checkOutput("rst_issue_cnt", W'(bus.issue_cnt), W'(0));
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_phv_ready", W'(bus.phv_ready_out), W'(1));
        checkOutput("post_rst_act_ready", W'(bus.action_ready_out), W'(1));

        // Aligned pair: pulse two cycles after the push
        applyStimulus(1'b1, a5Pattern(), 1'b1, ACT_W'(1), 1'b1);
        checkOutput("aligned_no_early_pulse", W'(bus.phv_valid_out), W'(0));
        idle(1'b1);
        checkOutput("aligned_valid", W'(bus.phv_valid_out), W'(1));
        checkOutput("aligned_act_valid", W'(bus.action_valid_out), W'(1));
        checkOutput("aligned_phv", W'(bus.phv_out), W'(a5Pattern()));
        checkOutput("aligned_act", W'(bus.action_out), W'(ACT_W'(1)));
        checkOutput("aligned_issue_cnt", W'(bus.issue_cnt), W'(1));
        idle(1'b1);
        checkOutput("aligned_single_pulse", W'(bus.phv_valid_out), W'(0));

        // Skew: action arrives three cycles after its PHV
        applyStimulus(1'b1, mkPhv(1), 1'b0, '0, 1'b1);
        checkOutput("skew_phv_cnt0", W'(bus.phv_cnt), W'(1));
        idle(1'b1);
        checkOutput("skew_phv_cnt1", W'(bus.phv_cnt), W'(1));
        idle(1'b1);
        checkOutput("skew_phv_cnt2", W'(bus.phv_cnt), W'(1));
        applyStimulus(1'b0, '0, 1'b1, mkAct(1), 1'b1);
        checkOutput("skew_no_pulse_yet", W'(bus.phv_valid_out), W'(0));
        idle(1'b1);
        checkOutput("skew_valid", W'(bus.phv_valid_out), W'(1));
        checkOutput("skew_phv", W'(bus.phv_out), W'(mkPhv(1)));
        checkOutput("skew_act", W'(bus.action_out), W'(mkAct(1)));
        checkOutput("skew_issue_cnt", W'(bus.issue_cnt), W'(2));

        // Backpressure: four pairs fill both FIFOs, a fifth PHV is dropped
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, mkPhv(10 + k), 1'b1, mkAct(10 + k), 1'b0);
        checkOutput("bp_phv_cnt", W'(bus.phv_cnt), W'(4));
        checkOutput("bp_act_cnt", W'(bus.act_cnt), W'(4));
        checkOutput("bp_phv_ready", W'(bus.phv_ready_out), W'(0));
        checkOutput("bp_act_ready", W'(bus.action_ready_out), W'(0));
        applyStimulus(1'b1, mkPhv(99), 1'b0, '0, 1'b0);
        checkOutput("bp_ovf", W'(bus.ovf_err), W'(2'b10));
        repeat (5) idle(1'b0);
        for (int k = 0; k < 4; k++) begin
            idle(1'b1);
            checkOutput("bp_drain_valid", W'(bus.phv_valid_out), W'(1));
            checkOutput("bp_drain_phv", W'(bus.phv_out), W'(mkPhv(10 + k)));
            checkOutput("bp_drain_act", W'(bus.action_out), W'(mkAct(10 + k)));
        end
        idle(1'b1);
        checkOutput("bp_drain_done", W'(bus.phv_valid_out), W'(0));
        checkOutput("bp_issue_cnt", W'(bus.issue_cnt), W'(6));
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        checkOutput("err_clr", W'(bus.ovf_err), W'(0));

        // Stream: 100 back-to-back pairs with the engine always ready
        pulseBase = pulseCount;
        for (int k = 0; k < 100; k++) applyStimulus(1'b1, mkPhv(100 + k), 1'b1, mkAct(100 + k), 1'b1);
        idle(1'b1);
        idle(1'b1);
        checkOutput("stream_pulses", W'(pulseCount - pulseBase), W'(100));
        checkOutput("stream_issue_cnt", W'(bus.issue_cnt), W'(106));

        // Flush with 3 PHVs and 1 action buffered
        applyStimulus(1'b1, mkPhv(300), 1'b1, mkAct(300), 1'b0);
        applyStimulus(1'b1, mkPhv(301), 1'b0, '0, 1'b0);
        applyStimulus(1'b1, mkPhv(302), 1'b0, '0, 1'b0);
        checkOutput("flush_pre_phv_cnt", W'(bus.phv_cnt), W'(3));
        checkOutput("flush_pre_act_cnt", W'(bus.act_cnt), W'(1));
        applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
        checkOutput("flush_no_issue", W'(bus.phv_valid_out), W'(0));
        checkOutput("flush_ready_low", W'(bus.phv_ready_out), W'(0));
        idle(1'b1);
        checkOutput("flush_phv_cnt", W'(bus.phv_cnt), W'(0));
        checkOutput("flush_act_cnt", W'(bus.act_cnt), W'(0));
        checkOutput("flush_no_issue2", W'(bus.phv_valid_out), W'(0));
        applyStimulus(1'b1, mkPhv(310), 1'b1, mkAct(310), 1'b1);
        idle(1'b1);
        checkOutput("flush_after_valid", W'(bus.phv_valid_out), W'(1));
        checkOutput("flush_after_phv", W'(bus.phv_out), W'(mkPhv(310)));
        checkOutput("flush_after_issue_cnt", W'(bus.issue_cnt), W'(107));

        // Reset mid-operation with two pairs buffered and the engine stalled
        applyStimulus(1'b1, mkPhv(400), 1'b1, mkAct(400), 1'b0);
        applyStimulus(1'b1, mkPhv(401), 1'b1, mkAct(401), 1'b0);
        rst_n = 1'b0;
        idle(1'b0);
        checkOutput("mid_rst_issue_cnt", W'(bus.issue_cnt), W'(0));
        checkOutput("mid_rst_phv_cnt", W'(bus.phv_cnt), W'(0));
        checkOutput("mid_rst_phv_out", W'(bus.phv_out), W'(0));
        checkOutput("mid_rst_valid", W'(bus.phv_valid_out), W'(0));
        checkOutput("mid_rst_ready", W'(bus.action_ready_out), W'(0));
        rst_n = 1'b1;
        applyStimulus(1'b1, mkPhv(500), 1'b1, mkAct(500), 1'b1);
        checkOutput("post_rst_no_early", W'(bus.phv_valid_out), W'(0));
        idle(1'b1);
        checkOutput("post_rst_valid", W'(bus.phv_valid_out), W'(1));
        checkOutput("post_rst_act", W'(bus.action_out), W'(mkAct(500)));
        checkOutput("post_rst_issue_cnt", W'(bus.issue_cnt), W'(1));
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/phv_action_issue_sched.md
Name: phv_action_issue_sched

Overview:
- Pairs each PHV from the parser/previous stage with its action word from the lookup engine, buffering whichever arrives first.
- Issues each pair to the stage's action engine as a single-cycle valid pulse, and only while the engine reports ready.
- The engine's stateful ALU can deassert ready, so this block is the per-stage sequencer that absorbs lookup/PHV skew and backpressure.

Parameters:
- PHV_LEN, 1124 (48*8+32*8+16*8+5*20+256): PHV width.
- ACT_LEN, 25: width of one sub-action.
- ACT_NUM, 25: sub-actions per action word; the action bus is ACT_LEN*ACT_NUM.
- FIFO_DEPTH, 4: entries per FIFO; must be a power of 2, at least 2.
- CNT_W, $clog2(FIFO_DEPTH)+1: width of the occupancy counts.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- phv_in  in  PHV_LEN  incoming PHV
- phv_valid_in  in  1  PHV beat valid
- phv_ready_out  out  1  PHV FIFO can accept
- action_in  in  ACT_LEN*ACT_NUM  incoming action word
- action_valid_in  in  1  action beat valid
- action_ready_out  out  1  action FIFO can accept
- phv_out  out  PHV_LEN  PHV to the action engine
- phv_valid_out  out  1  one-cycle issue pulse
- action_out  out  ACT_LEN*ACT_NUM  action to the action engine
- action_valid_out  out  1  equals phv_valid_out
- engine_ready_in  in  1  action engine ready
- flush_in  in  1  discard all buffered beats
- phv_cnt  out  CNT_W  PHV FIFO occupancy
- act_cnt  out  CNT_W  action FIFO occupancy
- ovf_err  out  2  sticky drop flags: [1] PHV, [0] action
- err_clr  in  1  clears ovf_err
- issue_cnt  out  32  pairs issued; wraps modulo 2^32

Behaviour:
- One clock, clk. Reset is synchronous, active-low on rst_n.
- Reset values: all outputs 0, FIFOs empty, state RUN. The ready outputs are 0 during reset and 1 in the first cycle after reset release.

FIFOs:
- Two independent FIFOs of FIFO_DEPTH entries, indexed by pointer plus count.
- phv_ready_out = !phv_full and action_ready_out = !act_full. Both are combinational from the count only, never from a pop in the same cycle. A full FIFO therefore rejects a push even if it pops that cycle.
- A push happens when valid_in=1, the FIFO is not full and state is RUN.
- If valid_in=1 while full, the beat is dropped and the matching ovf_err bit is set.
- Pointers wrap modulo FIFO_DEPTH.

Issue:
- Combinational condition: state==RUN, both FIFOs non-empty, engine_ready_in=1.
- On issue, both heads are popped and registered into phv_out/action_out, and phv_valid_out=action_valid_out=1 in the next cycle only.
- In non-issue cycles the valids are 0 and the data registers hold their last value.
- Latency: a pair pushed in cycle N (both FIFOs empty) produces the valid pulse in cycle N+2 if engine_ready_in=1 in N+1.
- Throughput: 1 pair per cycle while the engine is ready.
- A push and a pop on the same FIFO in one cycle keep the count unchanged.

State machine:
- RUN to FLUSH when flush_in=1. In that cycle no push or issue occurs and the valids are 0 next cycle.
- FLUSH clears pointers, counts and the output valids, then returns to RUN after one cycle.
- While in FLUSH the ready outputs are 0.
- flush_in held high keeps the block in FLUSH.

Errors and counters:
- err_clr has priority below a same-cycle new drop: the bit being set stays 1.
- issue_cnt increments on each issue and is unaffected by flush.
- Reset mid-operation discards all entries and any pending pulse; issue_cnt goes to 0.
- Pairing is strictly in arrival order. No tag check is made; lookup order is guaranteed by the pipeline.

Decomposition:
- Shared package: PHV_LEN, ACT_LEN, ACT_NUM default constants, the sub-action slot-index constants shared with the crossbar/ALU blocks, and the state encoding (RUN=0, FLUSH=1).
- One natural sub-module, sched_sync_fifo (parameterized WIDTH and DEPTH, with full/empty/count), instantiated twice. The controller, issue registers and counters live in the top.

Test Plan:
- Aligned pair: PHV=0xA5 pattern and action=0x1 pushed in cycle 0 with engine ready → valids high in cycle 2 only, data match, issue_cnt=1.
- Skew: action arrives 3 cycles after its PHV → phv_cnt=1 during the gap, pulse 2 cycles after the action push, correct pairing.
- Backpressure: engine_ready_in=0 for 10 cycles while 4 pairs arrive → counts reach 4 and the ready outputs drop. A 5th PHV with valid sets ovf_err=2'b10. On ready, 4 pulses occur in consecutive cycles in FIFO order.
- Stream: 100 pairs back-to-back with engine always ready → 100 single-cycle pulses, no gaps after the first, issue_cnt=100.
- Flush: 3 PHVs and 1 action buffered, flush_in pulsed → no issue, counts 0 two cycles later, next aligned pair issues normally.
- Reset with 2 pairs buffered and engine stalled → all outputs 0, issue_cnt=0. The first pair after release issues with 2-cycle latency.
